// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state definitions for the multi-cycle ALU and its bench.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADDU = 4'd0,
        OP_SUBU = 4'd1,
        OP_ADDS = 4'd2,
        OP_SUBS = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MULU = 4'd10,
        OP_CMP  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    localparam int OP_W = 4;

    // Codes 12..15 are reserved and flagged as illegal.
    function automatic logic op_is_legal(input logic [OP_W-1:0] code);
        return code <= 4'd11;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one partial-product step per cycle, WIDTH steps total.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    logic               busy;

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                                input logic [WIDTH-1:0]   mc);
        logic [WIDTH:0] sum;
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mc} : '0);
        return {sum, p[WIDTH-1:1]};
    endfunction

    // The first step is taken on the start edge so the last lands WIDTH-1 edges later.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            mcand <= '0;
            prod  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            mcand <= a;
            prod  <= step({{WIDTH{1'b0}}, b}, a);
            cnt   <= CW'(1);
            busy  <= 1'b1;
        end else if (busy) begin
            if (cnt == CW'(WIDTH)) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                prod <= step(prod, mcand);
                cnt  <= cnt + 1'b1;
            end
        end
    end

    assign done    = busy && (cnt == CW'(WIDTH));
    assign product = prod;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops via EXEC, MULU via the iterative multiplier,
// results and flags held in registers until the consumer takes them.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cf,
    output logic             ovf,
    output logic             z,
    output logic             neg,
    output logic             illegal,
    output alu_state_e       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // valid never depends on ready, and the producer holds its data until the transfer.

    localparam int SHW = $clog2(WIDTH);
    localparam int M   = WIDTH - 1;

    alu_state_e state, state_next;

    logic             accept, mul_start, load_exec, load_mul, mul_done;
    logic [WIDTH-1:0] a_r, b_r;
    logic [3:0]       op_r;
    logic [2*WIDTH-1:0] mul_product;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        mul_start  = 1'b0;
        load_exec  = 1'b0;
        load_mul   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (op == OP_MULU) begin
                        mul_start  = 1'b1;
                        state_next = ST_MUL;
                    end else begin
                        state_next = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                load_exec  = 1'b1;
                state_next = ST_DONE;
            end
            ST_MUL: begin
                if (mul_done) begin
                    load_mul   = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign dbg_state = state;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            a_r  <= '0;
            b_r  <= '0;
            op_r <= '0;
        end else if (accept) begin
            a_r  <= a;
            b_r  <= b;
            op_r <= op;
        end
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .areset  (areset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    logic [WIDTH:0]   add_w, sub_w, sll_w, srl_w, sra_w;
    logic [SHW-1:0]   shamt;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] x_res;
    logic             x_cf, x_ovf, x_z, x_neg, x_ill;

    // Shifts run one bit wider so the last bit shifted out lands in the extra bit.
    always_comb begin
        shamt   = b_r[SHW-1:0];
        add_w   = {1'b0, a_r} + {1'b0, b_r};
        sub_w   = {1'b0, a_r} - {1'b0, b_r};
        sll_w   = {1'b0, a_r} << shamt;
        srl_w   = {a_r, 1'b0} >> shamt;
        sra_w   = $signed({a_r, 1'b0}) >>> shamt;
        add_ovf = (a_r[M] == b_r[M]) && (add_w[M] != a_r[M]);
        sub_ovf = (a_r[M] != b_r[M]) && (sub_w[M] != a_r[M]);

        x_res = '0;
        x_cf  = 1'b0;
        x_ovf = 1'b0;
        x_ill = !op_is_legal(op_r);
        case (op_r)
            OP_ADDU: begin x_res = add_w[M:0]; x_cf = add_w[WIDTH]; end
            OP_SUBU: begin x_res = sub_w[M:0]; x_cf = ~sub_w[WIDTH]; end
            OP_ADDS: begin x_res = add_w[M:0]; x_ovf = add_ovf; end
            OP_SUBS: begin x_res = sub_w[M:0]; x_ovf = sub_ovf; end
            OP_AND:  x_res = a_r & b_r;
            OP_OR:   x_res = a_r | b_r;
            OP_XOR:  x_res = a_r ^ b_r;
            OP_SLL:  begin x_res = sll_w[M:0];     x_cf = sll_w[WIDTH]; end
            OP_SRL:  begin x_res = srl_w[WIDTH:1]; x_cf = srl_w[0]; end
            OP_SRA:  begin x_res = sra_w[WIDTH:1]; x_cf = sra_w[0]; end
            OP_CMP:  begin x_cf = ~sub_w[WIDTH]; x_ovf = sub_ovf; end
            default: ;
        endcase

        x_z   = (x_res == '0);
        x_neg = x_res[M];
        if (op_r == OP_CMP) begin
            x_z   = (a_r == b_r);
            x_neg = sub_w[M];
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            result    <= '0;
            result_hi <= '0;
            cf        <= 1'b0;
            ovf       <= 1'b0;
            z         <= 1'b0;
            neg       <= 1'b0;
            illegal   <= 1'b0;
        end else if (load_exec) begin
            result    <= x_res;
            result_hi <= '0;
            cf        <= x_cf;
            ovf       <= x_ovf;
            z         <= x_z;
            neg       <= x_neg;
            illegal   <= x_ill;
        end else if (load_mul) begin
            result    <= mul_product[WIDTH-1:0];
            result_hi <= mul_product[2*WIDTH-1:WIDTH];
            cf        <= |mul_product[2*WIDTH-1:WIDTH];
            ovf       <= 1'b0;
            z         <= ~|mul_product[WIDTH-1:0];
            neg       <= mul_product[M];
            illegal   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at WIDTH=8: vector table, random ops, hold and reset corners.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk, areset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [3:0]   op;
    logic [W-1:0] a, b, result, result_hi;
    logic         cf, ovf, z, neg, illegal;
    alu_state_e   dbg_state;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .cf(cf), .ovf(ovf), .z(z),
        .neg(neg), .illegal(illegal), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] res;
        logic cf, ovf, z, neg, ill;
    } exp_t;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] o, input logic [W-1:0] va, vb,
                                 input logic [W-1:0] hi, res,
                                 input logic c, v, zz, n, il);
        vec_t t;
        t.op = o; t.a = va; t.b = vb;
        t.e.hi = hi; t.e.res = res;
        t.e.cf = c; t.e.ovf = v; t.e.z = zz; t.e.neg = n; t.e.ill = il;
        return t;
    endfunction

    // Arithmetic reference for the randomised subset, written with integer math.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] va, vb);
        exp_t e;
        int   ia, ib, r;
        ia = int'(va); ib = int'(vb);
        e = '0;
        case (o)
            OP_ADDU: begin r = ia + ib; e.res = W'(r % 256); e.cf = (r > 255); end
            OP_SUBU: begin r = ia - ib + 256; e.res = W'(r % 256); e.cf = (ia >= ib); end
            OP_AND:  e.res = va & vb;
            OP_XOR:  e.res = va ^ vb;
            default: begin r = ia * ib; e.res = W'(r % 256); e.hi = W'(r / 256); e.cf = (r > 255); end
        endcase
        e.z   = (e.res == 0);
        e.neg = e.res[W-1];
        return e;
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] va, vb,
                          input exp_t e, input int hold, input string name);
        int   lat, exp_lat;
        bit   leak, unstable;
        exp_t got, want;
        exp_lat = (o == OP_MULU) ? W + 1 : 2;
        @(negedge clk);
        check({name, " in_ready idle"}, in_ready, 1);
        op = o; a = va; b = vb; in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 4'($urandom_range(0, 15));
        lat = 1; leak = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready) leak = 1;
            @(negedge clk);
            lat++;
        end
        check({name, " out_valid seen"}, out_valid, 1);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " in_ready low busy"}, leak, 0);
        want = exp_q.pop_front();
        if (out_valid !== 1'b1) return;
        got = {result_hi, result, cf, ovf, z, neg, illegal};
        check({name, " result/flags"}, got, want);
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if ({out_valid, in_ready, result_hi, result, cf, ovf, z, neg, illegal}
                !== {1'b1, 1'b0, got}) unstable = 1;
        end
        if (hold > 0) check({name, " hold stable"}, unstable, 0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " back to idle"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        bit stray;
        areset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;

        vecs.push_back(mkv(OP_ADDU, 8'hFF, 8'h01, 8'h00, 8'h00, 1, 0, 1, 0, 0));
        vecs.push_back(mkv(OP_ADDU, 8'h3C, 8'h42, 8'h00, 8'h7E, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(OP_ADDS, 8'h7F, 8'h01, 8'h00, 8'h80, 0, 1, 0, 1, 0));
        vecs.push_back(mkv(OP_ADDS, 8'h80, 8'h80, 8'h00, 8'h00, 0, 1, 1, 0, 0));
        vecs.push_back(mkv(OP_SUBU, 8'h05, 8'h07, 8'h00, 8'hFE, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(OP_SUBU, 8'h07, 8'h05, 8'h00, 8'h02, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(OP_SUBS, 8'h80, 8'h01, 8'h00, 8'h7F, 0, 1, 0, 0, 0));
        vecs.push_back(mkv(OP_AND,  8'hF0, 8'h3C, 8'h00, 8'h30, 0, 0, 0, 0, 0));
        vecs.push_back(mkv(OP_OR,   8'hF0, 8'h0F, 8'h00, 8'hFF, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(OP_XOR,  8'hAA, 8'hAA, 8'h00, 8'h00, 0, 0, 1, 0, 0));
        vecs.push_back(mkv(OP_SLL,  8'h81, 8'h01, 8'h00, 8'h02, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(OP_SLL,  8'h81, 8'h08, 8'h00, 8'h81, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(OP_SRL,  8'hC0, 8'h07, 8'h00, 8'h01, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(OP_SRA,  8'h90, 8'h03, 8'h00, 8'hF2, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(OP_SRA,  8'h90, 8'h07, 8'h00, 8'hFF, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(OP_MULU, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1, 0, 0, 0, 0));
        vecs.push_back(mkv(OP_MULU, 8'h10, 8'h10, 8'h01, 8'h00, 1, 0, 1, 0, 0));
        vecs.push_back(mkv(OP_MULU, 8'h00, 8'h37, 8'h00, 8'h00, 0, 0, 1, 0, 0));
        vecs.push_back(mkv(OP_CMP,  8'h05, 8'h05, 8'h00, 8'h00, 1, 0, 1, 0, 0));
        vecs.push_back(mkv(OP_CMP,  8'h03, 8'h05, 8'h00, 8'h00, 0, 0, 0, 1, 0));
        vecs.push_back(mkv(OP_CMP,  8'h80, 8'h01, 8'h00, 8'h00, 1, 1, 0, 0, 0));
        vecs.push_back(mkv(4'd13,   8'h12, 8'h34, 8'h00, 8'h00, 0, 0, 1, 0, 1));
        vecs.push_back(mkv(4'd15,   8'hFF, 8'hFF, 8'h00, 8'h00, 0, 0, 1, 0, 1));

        // Reset state
        repeat (3) @(negedge clk);
        check("reset state", dbg_state, ST_IDLE);
        check("reset handshake", {in_ready, out_valid}, 2'b10);
        check("reset outputs", {result_hi, result, cf, ovf, z, neg, illegal}, 0);
        @(posedge clk);
        #2 areset = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, 0, $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            logic [3:0]   ro;
            logic [W-1:0] ra, rb;
            case ($urandom_range(0, 4))
                0: ro = OP_ADDU;
                1: ro = OP_SUBU;
                2: ro = OP_AND;
                3: ro = OP_XOR;
                default: ro = OP_MULU;
            endcase
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            run_op(ro, ra, rb, model(ro, ra, rb), 0, $sformatf("rnd%0d", i));
        end

        // Consumer stalls for 5 cycles in DONE
        run_op(OP_ADDS, 8'h7F, 8'h01, mkv(OP_ADDS, 0, 0, 8'h00, 8'h80, 0, 1, 0, 1, 0).e,
               5, "stall adds");
        run_op(OP_MULU, 8'hFF, 8'hFF, mkv(OP_MULU, 0, 0, 8'hFE, 8'h01, 1, 0, 0, 0, 0).e,
               5, "stall mulu");

        // Reset pulsed during the 4th MUL cycle abandons the multiply
        @(negedge clk);
        op = OP_MULU; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-mul state", dbg_state, ST_MUL);
        areset = 1'b1;
        #2;
        check("mid-mul reset state", dbg_state, ST_IDLE);
        check("mid-mul reset outputs", {in_ready, out_valid, result_hi, result}, {2'b10, 16'h0});
        @(negedge clk);
        areset = 1'b0;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) stray = 1;
        end
        check("no out_valid after abort", stray, 0);
        run_op(OP_ADDU, 8'h12, 8'h34, mkv(OP_ADDU, 0, 0, 8'h00, 8'h46, 0, 0, 0, 0, 0).e,
               0, "post-reset addu");

        check("scoreboard drained", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand/result width; legal values 4..32, powers of two.
REQ-002 The block SHALL have localparam SHW = log2(WIDTH), the shift-amount width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 areset  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 op  input  4  operation code, encoded per REQ-013.
REQ-008 a, b  input  WIDTH  operands, sampled on acceptance.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result, result_hi  output  WIDTH  low and high result words; result_hi is nonzero only for MULU.
REQ-012 cf, ovf, z, neg, illegal  output  1 each  carry, signed overflow, zero, negative, and illegal-opcode flags.

Function
REQ-013 Op encoding SHALL be: 0 ADDU, 1 SUBU, 2 ADDS, 3 SUBS, 4 AND, 5 OR, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 MULU, 11 CMP; 12-15 are illegal.
REQ-014 Acceptance SHALL occur on a rising edge with in_valid && in_ready; a, b and op SHALL be captured at that edge.
REQ-015 FSM SHALL have states IDLE, EXEC, MUL and DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 IDLE SHALL go to MUL on acceptance of MULU, to EXEC on acceptance of any other op, and otherwise stay in IDLE.
REQ-017 EXEC SHALL compute the result in one cycle, then go to DONE, giving out_valid exactly 2 cycles after acceptance.
REQ-018 MUL SHALL perform an unsigned shift-add over WIDTH cycles, then go to DONE, giving out_valid WIDTH+1 cycles after acceptance.
REQ-019 DONE SHALL assert out_valid and hold all outputs stable until out_ready=1, then return to IDLE.
REQ-020 A new op SHALL be accepted no earlier than the cycle after the result handshake.
REQ-021 ADDU: cf SHALL be the carry out of the WIDTH-bit sum; ovf=0.
REQ-022 SUBU: result=a-b mod 2^WIDTH; cf=1 iff a>=b (unsigned), i.e. no borrow; ovf=0.
REQ-023 ADDS/SUBS: two's-complement result; ovf SHALL follow the sign rule (add: same-sign operands giving a different-sign result; sub: differing-sign operands giving a result whose sign differs from a); cf=0.
REQ-024 AND/OR/XOR: bitwise result; cf=ovf=0.
REQ-025 SLL/SRL/SRA shift amount SHALL be b[SHW-1:0]; cf SHALL be the last bit shifted out, and 0 for an amount of 0; SRA SHALL sign-fill; ovf=0.
REQ-026 MULU: {result_hi,result}=a*b (unsigned, 2*WIDTH bits); cf=1 iff result_hi!=0; ovf=0.
REQ-027 CMP SHALL compute a-b for flags only: result=0; cf per SUBU; ovf per SUBS; z=1 iff a==b; neg=MSB of the difference.
REQ-028 For all ops except CMP, z SHALL be 1 iff result==0 (result_hi excluded) and neg SHALL equal result[WIDTH-1].
REQ-029 Illegal op SHALL take the EXEC path and give result=result_hi=0, illegal=1, z=1, and cf=ovf=neg=0.
REQ-030 result_hi SHALL be 0 for all non-MULU ops; illegal SHALL be 0 for legal ops.
REQ-031 Flags SHALL be registered together with result; there SHALL be no combinational path from inputs to outputs except in_ready from state.

Reset
REQ-032 While areset is high, the block SHALL be in IDLE with in_ready=1, out_valid=0, all result words and flags 0, and the multiply counter and accumulator cleared.
REQ-033 Reset mid-MUL or in DONE SHALL abandon the operation, and no out_valid SHALL appear for it after release.
REQ-034 The first acceptance SHALL be possible on the first clk edge after areset deasserts.

Structure
REQ-035 Op codes and the FSM state enum SHALL reside in a shared package alu_pkg, reused by the decoder and the bench.
REQ-036 The iterative multiplier SHALL be a sub-module alu_mul_iter with start/done, a WIDTH parameter and a 2*WIDTH product output; all other ops SHALL stay in alu_mc.

Verification (WIDTH=8)
REQ-037 ADDU a=0xFF, b=0x01 -> result=0x00, cf=1, z=1, out_valid 2 cycles after acceptance.
REQ-038 ADDS a=0x7F, b=0x01 -> result=0x80, ovf=1, neg=1, cf=0.
REQ-039 MULU a=0xFF, b=0xFF -> result_hi=0xFE, result=0x01, cf=1, out_valid at acceptance+9; in_ready=0 throughout.
REQ-040 SRA a=0x90, b=0x03 -> result=0xF2, cf=0, neg=1; SLL a=0x81, b=0x01 -> result=0x02, cf=1.
REQ-041 CMP a=0x05, b=0x05 -> result=0, z=1, cf=1; op=13 -> illegal=1, result=0.
REQ-042 out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; areset pulsed at MUL cycle 4 -> IDLE, no out_valid, next ADDU completes normally.
